reg_file_param: RTL and testbench



---
 rtl/reg_file_pkg.sv | 10 +
 rtl/reg_file_param_reg_word.sv | 35 +++
 rtl/reg_file_param.sv | 79 +++++++
 tb/tb_reg_file_param.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and word type for the parametrised register file.
package reg_file_pkg;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_NUM_RD = 2;

    typedef logic [DEF_WIDTH-1:0] word_t;

endpackage

// File: rtl/reg_file_param_reg_word.sv
// Single storage word: synchronous active-low clear, load on we.
module reg_word
    import reg_file_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] word_q;
    logic [WIDTH-1:0] word_d;

    // Clear wins over a load in the same cycle.
    always_comb begin
        word_d = word_q;
        if (we) begin
            word_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= '0;
        end else begin
            word_q <= word_d;
        end
    end

    assign q = word_q;

endmodule

// File: rtl/reg_file_param.sv
// Multi-port register file: one synchronous write port, NUM_RD combinational
// mux read ports with optional write-to-read bypass and hardwired zero word.
module reg_file_param
    import reg_file_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int DEPTH    = DEF_DEPTH,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               we,
    input  logic [$clog2(DEPTH)-1:0]           waddr,
    input  logic [WIDTH-1:0]                   wdata,
    input  logic [NUM_RD-1:0]                  re,
    input  logic [NUM_RD*$clog2(DEPTH)-1:0]    raddr,
    output logic [NUM_RD*WIDTH-1:0]            rdata
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] words;

    for (genvar w = 0; w < DEPTH; w++) begin : g_word
        if (ZERO_REG != 0 && w == 0) begin : g_zero
            assign words[w] = '0;
        end else begin : g_reg
            logic wen;
            // Out-of-range write addresses never match any word index.
            assign wen = we && (waddr == AW'(w));
            reg_word #(.WIDTH(WIDTH)) u_word (
                .clk   (clk),
                .rst_n (rst_n),
                .we    (wen),
                .d     (wdata),
                .q     (words[w])
            );
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [AW-1:0]    addr;
        logic [WIDTH-1:0] sel;
        logic [WIDTH-1:0] rd_val;

        assign addr = raddr[i*AW +: AW];

        always_comb begin
            sel = '0;
            for (int w = 0; w < DEPTH; w++) begin
                if (addr == AW'(w)) begin
                    sel = words[w];
                end
            end
        end

        // Priority: disabled, out of range, zero word, bypass, storage.
        always_comb begin
            rd_val = '0;
            if (!re[i]) begin
                rd_val = '0;
            end else if ({1'b0, addr} >= DEPTH_L) begin
                rd_val = '0;
            end else if (ZERO_REG != 0 && addr == '0) begin
                rd_val = '0;
            end else if (BYPASS != 0 && we && waddr == addr) begin
                rd_val = wdata;
            end else begin
                rd_val = sel;
            end
        end

        assign rdata[i*WIDTH +: WIDTH] = rd_val;
    end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench: three register-file configurations share one stimulus bus.
module tb_reg_file_param;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [3:0]  waddr;
    logic [15:0] wdata;
    logic [1:0]  re;
    logic [7:0]  raddr;
    logic [31:0] rdata_a;
    logic [31:0] rdata_b;
    logic [31:0] rdata_c;

    int errors;
    int checks;
    logic [15:0] exp_q[$];

    // a: defaults (ZERO_REG=1, BYPASS=1); b: no bypass, no zero word; c: DEPTH=12
    reg_file_param #(.WIDTH(16), .DEPTH(16), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata_a)
    );
    reg_file_param #(.WIDTH(16), .DEPTH(16), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata_b)
    );
    reg_file_param #(.WIDTH(16), .DEPTH(12), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_dut_c (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .re(re), .raddr(raddr), .rdata(rdata_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [3:0] a, input logic [15:0] d);
        we = 1'b1;
        waddr = a;
        wdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic set_read(input logic [3:0] a1, input logic [3:0] a0, input logic [1:0] en);
        raddr = {a1, a0};
        re = en;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        we = 1'b0;
        waddr = '0;
        wdata = '0;
        re = '0;
        raddr = '0;
        step();
        step();
        rst_n = 1'b1;
        for (int a = 0; a < 16; a++) begin
            set_read(4'(a), 4'(a), 2'b11);
            checks++;
            if (rdata_a !== 32'h0) begin
                errors++;
                $display("FAIL reset_sweep_a addr=%0d got=%h exp=%h", a, rdata_a, 32'h0);
            end
            checks++;
            if (rdata_b !== 32'h0) begin
                errors++;
                $display("FAIL reset_sweep_b addr=%0d got=%h exp=%h", a, rdata_b, 32'h0);
            end
            checks++;
            if (rdata_c !== 32'h0) begin
                errors++;
                $display("FAIL reset_sweep_c addr=%0d got=%h exp=%h", a, rdata_c, 32'h0);
            end
        end
    endtask

    task automatic test_write_read();
        write_reg(4'd3, 16'hA5A5);
        set_read(4'd3, 4'd3, 2'b11);
        checks++;
        if (rdata_a !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL dual_read_a got=%h exp=%h", rdata_a, 32'hA5A5_A5A5);
        end
        checks++;
        if (rdata_b !== 32'hA5A5_A5A5) begin
            errors++;
            $display("FAIL dual_read_b got=%h exp=%h", rdata_b, 32'hA5A5_A5A5);
        end
        set_read(4'd3, 4'd3, 2'b01);
        checks++;
        if (rdata_a !== 32'h0000_A5A5) begin
            errors++;
            $display("FAIL read_disable got=%h exp=%h", rdata_a, 32'h0000_A5A5);
        end
    endtask

    task automatic test_bypass();
        write_reg(4'd5, 16'h1111);
        we = 1'b1;
        waddr = 4'd5;
        wdata = 16'h2222;
        set_read(4'd0, 4'd5, 2'b01);
        checks++;
        if (rdata_a[15:0] !== 16'h2222) begin
            errors++;
            $display("FAIL bypass_on got=%h exp=%h", rdata_a[15:0], 16'h2222);
        end
        checks++;
        if (rdata_b[15:0] !== 16'h1111) begin
            errors++;
            $display("FAIL bypass_off_old got=%h exp=%h", rdata_b[15:0], 16'h1111);
        end
        step();
        we = 1'b0;
        #1;
        checks++;
        if (rdata_b[15:0] !== 16'h2222) begin
            errors++;
            $display("FAIL bypass_off_next got=%h exp=%h", rdata_b[15:0], 16'h2222);
        end
    endtask

    task automatic test_zero_reg();
        we = 1'b1;
        waddr = 4'd0;
        wdata = 16'hFFFF;
        set_read(4'd0, 4'd0, 2'b01);
        checks++;
        if (rdata_a[15:0] !== 16'h0000) begin
            errors++;
            $display("FAIL zero_same_cycle got=%h exp=%h", rdata_a[15:0], 16'h0000);
        end
        step();
        we = 1'b0;
        #1;
        checks++;
        if (rdata_a[15:0] !== 16'h0000) begin
            errors++;
            $display("FAIL zero_next_cycle got=%h exp=%h", rdata_a[15:0], 16'h0000);
        end
        checks++;
        if (rdata_b[15:0] !== 16'hFFFF) begin
            errors++;
            $display("FAIL nonzero_reg0 got=%h exp=%h", rdata_b[15:0], 16'hFFFF);
        end
    endtask

    task automatic test_depth12();
        write_reg(4'd11, 16'h0B0B);
        write_reg(4'd12, 16'hCCCC);
        we = 1'b1;
        waddr = 4'd13;
        wdata = 16'h1234;
        set_read(4'd12, 4'd13, 2'b11);
        checks++;
        if (rdata_c !== 32'h0) begin
            errors++;
            $display("FAIL d12_oob_bypass got=%h exp=%h", rdata_c, 32'h0);
        end
        step();
        we = 1'b0;
        #1;
        checks++;
        if (rdata_c !== 32'h0) begin
            errors++;
            $display("FAIL d12_oob_read got=%h exp=%h", rdata_c, 32'h0);
        end
        checks++;
        if (rdata_a !== 32'hCCCC_1234) begin
            errors++;
            $display("FAIL d16_high_regs got=%h exp=%h", rdata_a, 32'hCCCC_1234);
        end
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'hA5A5);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h2222);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0000);
        exp_q.push_back(16'h0B0B);
        for (int a = 0; a < 12; a++) begin
            logic [15:0] exp;
            exp = exp_q.pop_front();
            set_read(4'd0, 4'(a), 2'b01);
            checks++;
            if (rdata_c[15:0] !== exp) begin
                errors++;
                $display("FAIL d12_scoreboard addr=%0d got=%h exp=%h", a, rdata_c[15:0], exp);
            end
        end
    endtask

    task automatic test_reset_write();
        write_reg(4'd7, 16'hBEEF);
        set_read(4'd3, 4'd7, 2'b11);
        checks++;
        if (rdata_a !== 32'hA5A5_BEEF) begin
            errors++;
            $display("FAIL pre_reset got=%h exp=%h", rdata_a, 32'hA5A5_BEEF);
        end
        rst_n = 1'b0;
        we = 1'b1;
        waddr = 4'd7;
        wdata = 16'h5555;
        #1;
        checks++;
        if (rdata_a[15:0] !== 16'h5555) begin
            errors++;
            $display("FAIL reset_bypass got=%h exp=%h", rdata_a[15:0], 16'h5555);
        end
        checks++;
        if (rdata_b[15:0] !== 16'hBEEF) begin
            errors++;
            $display("FAIL reset_old_value got=%h exp=%h", rdata_b[15:0], 16'hBEEF);
        end
        step();
        rst_n = 1'b1;
        we = 1'b0;
        #1;
        checks++;
        if (rdata_a !== 32'h0) begin
            errors++;
            $display("FAIL reset_dominates_a got=%h exp=%h", rdata_a, 32'h0);
        end
        checks++;
        if (rdata_b !== 32'h0) begin
            errors++;
            $display("FAIL reset_dominates_b got=%h exp=%h", rdata_b, 32'h0);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_depth12();
        test_reset_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
